// File: rtl/eth_switch_pkg.sv
// Shared types and constants for the switch port datapath (XGMII TX side).
package eth_switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SFD,
    ST_DATA,
    ST_FCS,
    ST_TERM,
    ST_DRAIN,
    ST_IPG
  } eth_tx_state_t;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY_REV = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;

  // Number of valid bytes in a beat; anything other than a contiguous low-lane mask counts as 4.
  function automatic logic [2:0] keep_to_nbytes(input logic [3:0] keep);
    case (keep)
      4'b0001: return 3'd1;
      4'b0011: return 3'd2;
      4'b0111: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/eth_crc32_d32.sv
// Combinational CRC-32 (reflected) update over the low 1..4 bytes of a 32-bit word.
module eth_crc32_d32
  import eth_switch_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc_out
);

  logic [31:0] c;
  logic [31:0] d;
  logic [2:0]  left;

  // Fold bytes lane0 first, one bit at a time, LSB first.
  always_comb begin
    c    = crc_in;
    d    = data;
    left = nbytes;
    for (int b = 0; b < 4; b++) begin
      if (left != 3'd0) begin
        c = c ^ {24'h0, d[7:0]};
        for (int k = 0; k < 8; k++) begin
          c = c[0] ? ((c >> 1) ^ CRC32_POLY_REV) : (c >> 1);
        end
        left = left - 3'd1;
      end
      d = d >> 8;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_xgmii_tx.sv
// Egress XGMII transmitter: start/preamble/SFD, frame data, CRC-32 FCS, terminate and IPG.
module eth_xgmii_tx
  import eth_switch_pkg::*;
#(
  parameter int unsigned IPG_WORDS = 3  // must be >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic [3:0]  s_keep,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] txd,
  output logic [3:0]  txc,
  output logic        tx_busy,
  output logic        frame_sent,
  output logic        tx_underrun
);

  localparam logic [7:0]  IPG_INIT  = 8'(IPG_WORDS - 1);
  localparam logic [31:0] IDLE_WORD = {4{XGMII_IDLE}};

  eth_tx_state_t state;
  logic [7:0]    ipg_cnt;
  logic [31:0]   crc;
  logic [31:0]   fcs_rem;   // full FCS of the frame just closed
  logic [2:0]    n_last;    // valid bytes in that frame's last beat

  logic [2:0]    nbytes;
  logic [31:0]   crc_next;
  logic [31:0]   fcs_now;
  logic [31:0]   last_word;
  logic [31:0]   term_word;
  logic [3:0]    term_ctrl;

  assign nbytes  = keep_to_nbytes(s_keep);
  assign fcs_now = ~crc_next;
  assign s_ready = (state == ST_DATA) || (state == ST_DRAIN);
  assign tx_busy = (state != ST_IDLE);

  eth_crc32_d32 u_crc (
    .crc_in  (crc),
    .data    (s_data),
    .nbytes  (nbytes),
    .crc_out (crc_next)
  );

  // Word packing around the FCS: last beat carries its n bytes then FCS bytes 0..3-n;
  // the following word carries FCS bytes 4-n..3, then /T/ and idles.
  always_comb begin
    last_word = (s_data & ~(32'hFFFFFFFF << {nbytes, 3'b000}))
              | (fcs_now << {nbytes, 3'b000});
    term_word = ((fcs_rem >> {3'(3'd4 - n_last), 3'b000})
                 & ~(32'hFFFFFFFF << {n_last, 3'b000}))
              | ({XGMII_IDLE, XGMII_IDLE, XGMII_IDLE, XGMII_TERM} << {n_last, 3'b000});
    term_ctrl = 4'hF << n_last;
  end

  // Transmit FSM with registered XGMII word and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      txd         <= IDLE_WORD;
      txc         <= 4'hF;
      frame_sent  <= 1'b0;
      tx_underrun <= 1'b0;
      ipg_cnt     <= 8'd0;
      crc         <= CRC32_INIT;
      fcs_rem     <= 32'h0;
      n_last      <= 3'd4;
    end else begin
      txd         <= IDLE_WORD;
      txc         <= 4'hF;
      frame_sent  <= 1'b0;
      tx_underrun <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          crc <= CRC32_INIT;
          if (s_valid) begin
            txd   <= {PREAMBLE_BYTE, PREAMBLE_BYTE, PREAMBLE_BYTE, XGMII_START};
            txc   <= 4'b0001;
            state <= ST_SFD;
          end
        end
        ST_SFD: begin
          txd   <= {SFD_BYTE, PREAMBLE_BYTE, PREAMBLE_BYTE, PREAMBLE_BYTE};
          txc   <= 4'b0000;
          state <= ST_DATA;
        end
        ST_DATA: begin
          if (s_valid) begin
            txc <= 4'b0000;
            crc <= crc_next;
            if (s_last) begin
              txd     <= last_word;
              fcs_rem <= fcs_now;
              n_last  <= nbytes;
              state   <= ST_FCS;
            end else begin
              txd <= s_data;
            end
          end else begin
            txd         <= {4{XGMII_ERR}};
            txc         <= 4'hF;
            tx_underrun <= 1'b1;
            state       <= ST_DRAIN;
          end
        end
        ST_FCS: begin
          txd <= term_word;
          txc <= term_ctrl;
          if (n_last == 3'd4) begin
            state <= ST_TERM;
          end else begin
            frame_sent <= 1'b1;
            ipg_cnt    <= IPG_INIT;
            state      <= ST_IPG;
          end
        end
        ST_TERM: begin
          txd        <= {XGMII_IDLE, XGMII_IDLE, XGMII_IDLE, XGMII_TERM};
          txc        <= 4'hF;
          frame_sent <= 1'b1;
          ipg_cnt    <= IPG_INIT;
          state      <= ST_IPG;
        end
        ST_DRAIN: begin
          if (s_valid && s_last) begin
            ipg_cnt <= IPG_INIT;
            state   <= ST_IPG;
          end
        end
        ST_IPG: begin
          if (ipg_cnt == 8'd0) state <= ST_IDLE;
          else ipg_cnt <= ipg_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_xgmii_tx.sv
// Directed bench for eth_xgmii_tx: logs every TX word and checks framing, FCS and gaps.
module tb_eth_xgmii_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] txd;
  logic [3:0]  txc;
  logic        tx_busy;
  logic        frame_sent;
  logic        tx_underrun;

  eth_xgmii_tx #(.IPG_WORDS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_keep      (s_keep),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .txd         (txd),
    .txc         (txc),
    .tx_busy     (tx_busy),
    .frame_sent  (frame_sent),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word log, sampled on the falling edge.
  localparam int LOG_MAX = 512;
  logic [31:0] lg_d  [LOG_MAX];
  logic [3:0]  lg_c  [LOG_MAX];
  logic        lg_fs [LOG_MAX];
  logic        lg_ur [LOG_MAX];
  int          lg_n = 0;
  bit          lg_en = 1'b0;

  always @(negedge clk) begin
    if (lg_en && lg_n < LOG_MAX) begin
      lg_d[lg_n]  = txd;
      lg_c[lg_n]  = txc;
      lg_fs[lg_n] = frame_sent;
      lg_ur[lg_n] = tx_underrun;
      lg_n        = lg_n + 1;
    end
  end

  task automatic log_start();
    lg_n  = 0;
    lg_en = 1'b1;
  endtask

  logic [7:0] fb [256];  // frame bytes to send
  logic [7:0] rx [256];  // bytes recovered from the wire
  int         rx_n;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < len; k++) c = crc_upd(c, fb[k]);
    return ~c;
  endfunction

  function automatic int count_fs();
    int n;
    n = 0;
    for (int i = 0; i < lg_n; i++) if (lg_fs[i]) n++;
    return n;
  endfunction

  function automatic int count_ur();
    int n;
    n = 0;
    for (int i = 0; i < lg_n; i++) if (lg_ur[i]) n++;
    return n;
  endfunction

  // Drive a frame from fb. gap_at: drop s_valid for one cycle before that beat.
  // rst_at: pulse reset while that beat is presented, then abandon the frame.
  task automatic send_frame(input int len, input int gap_at, input int rst_at);
    int nbeats;
    int t;
    bit ok;
    nbeats = (len + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_data = '0;
      s_keep = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * b + l < len) begin
          s_data[8*l +: 8] = fb[4*b + l];
          s_keep[l]        = 1'b1;
        end
      end
      s_last  = (b == nbeats - 1);
      s_valid = 1'b1;
      if (b == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 50) begin
        @(negedge clk);
        if (s_ready) begin
          @(posedge clk);
          #1;
          ok = 1'b1;
        end
        t++;
      end
      if (!ok) begin
        check_eq("accept_timeout", 64'(ok), 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Locate the next start word and collect data bytes until the first control lane.
  task automatic parse_frame(input int from, output int st, output int term, output int lane);
    st   = -1;
    term = -1;
    lane = -1;
    rx_n = 0;
    for (int i = from; i < lg_n - 1; i++) begin
      if (lg_c[i] == 4'b0001 && lg_d[i] == 32'h555555FB) begin
        st = i;
        break;
      end
    end
    if (st < 0) return;
    for (int j = st + 2; j < lg_n && term < 0; j++) begin
      for (int l = 0; l < 4 && term < 0; l++) begin
        if (lg_c[j][l] == 1'b0) begin
          if (rx_n < 256) rx[rx_n] = lg_d[j][8*l +: 8];
          rx_n++;
        end else begin
          term = j;
          lane = l;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input int from, input int len,
                             output int st, output int term, output int lane);
    int          ndiff;
    logic [31:0] c;
    parse_frame(from, st, term, lane);
    check_eq({tag, "_start"}, 64'(st >= 0), 64'd1);
    if (st < 0) return;
    check_eq({tag, "_sfd"}, {lg_c[st+1], lg_d[st+1]}, {4'h0, 32'hD5555555});
    check_eq({tag, "_len"}, 64'(rx_n), 64'(len + 4));
    ndiff = 0;
    for (int k = 0; k < len; k++) if (rx[k] !== fb[k]) ndiff++;
    check_eq({tag, "_data"}, 64'(ndiff), 64'd0);
    check_eq({tag, "_fcs"}, {rx[len+3], rx[len+2], rx[len+1], rx[len]}, 64'(fcs_of(len)));
    c = 32'hFFFFFFFF;
    for (int k = 0; k < len + 4; k++) c = crc_upd(c, rx[k]);
    check_eq({tag, "_residue"}, 64'(c), 64'h0DEBB20E3);
    check_eq({tag, "_term_found"}, 64'(term >= 0), 64'd1);
    if (term < 0) return;
    check_eq({tag, "_term_char"}, 64'(lg_d[term][8*lane +: 8]), 64'hFD);
    check_eq({tag, "_fs_at_term"}, 64'(lg_fs[term]), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, term, lane, st2, term2, lane2, fe, cnt;
    logic [31:0] fcs;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_txd", 64'(txd), 64'h07070707);
    check_eq("rst_txc", 64'(txc), 64'hF);
    check_eq("rst_ready", 64'(s_ready), 64'd0);
    check_eq("rst_busy", 64'(tx_busy), 64'd0);
    check_eq("rst_pulses", {62'd0, frame_sent, tx_underrun}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: "123456789", last keep 0001
    for (int k = 0; k < 9; k++) fb[k] = 8'h31 + 8'(k);
    log_start();
    send_frame(9, -1, -1);
    repeat (12) @(negedge clk);
    lg_en = 1'b0;
    check_frame("t1", 0, 9, st, term, lane);
    if (term > 0) begin
      check_eq("t1_lastdata", {lg_c[term-1], lg_d[term-1]}, {4'h0, 32'hF4392639});
      check_eq("t1_termword", {lg_c[term], lg_d[term]}, {4'b1110, 32'h0707FDCB});
    end
    check_eq("t1_fs_cnt", 64'(count_fs()), 64'd1);
    check_eq("t1_idle_busy", 64'(tx_busy), 64'd0);

    // 2: 64-byte frame, last keep 1111
    for (int k = 0; k < 64; k++) fb[k] = 8'(k * 7 + 3);
    log_start();
    send_frame(64, -1, -1);
    repeat (12) @(negedge clk);
    lg_en = 1'b0;
    check_frame("t2", 0, 64, st, term, lane);
    if (term > 0) begin
      check_eq("t2_fcsword", {lg_c[term-1], lg_d[term-1]}, {4'h0, fcs_of(64)});
      check_eq("t2_termword", {lg_c[term], lg_d[term]}, {4'hF, 32'h070707FD});
    end

    // 3: back-to-back frames
    for (int k = 0; k < 20; k++) fb[k] = 8'(k) ^ 8'hA5;
    log_start();
    send_frame(20, -1, -1);
    send_frame(13, -1, -1);
    repeat (14) @(negedge clk);
    lg_en = 1'b0;
    check_frame("t3a", 0, 20, st, term, lane);
    check_frame("t3b", term + 1, 13, st2, term2, lane2);
    check_eq("t3_gap", 64'(st2 - term - 1), 64'd3);
    cnt = 0;
    for (int i = term + 1; i < st2; i++) if (lg_c[i] == 4'hF && lg_d[i] == 32'h07070707) cnt++;
    check_eq("t3_idles", 64'(cnt), 64'd3);

    // 4: underrun after 5 beats of an 8-beat frame
    for (int k = 0; k < 32; k++) fb[k] = 8'(k + 8'h40);
    log_start();
    send_frame(32, 5, -1);
    repeat (12) @(negedge clk);
    lg_en = 1'b0;
    parse_frame(0, st, term, lane);
    fe  = -1;
    cnt = 0;
    for (int i = 0; i < lg_n; i++) begin
      if (lg_c[i] == 4'hF && lg_d[i] == 32'hFEFEFEFE) begin
        cnt++;
        if (fe < 0) fe = i;
      end
    end
    check_eq("t4_fe_cnt", 64'(cnt), 64'd1);
    check_eq("t4_ur_cnt", 64'(count_ur()), 64'd1);
    check_eq("t4_fs_cnt", 64'(count_fs()), 64'd0);
    if (fe > 0 && st >= 0) begin
      check_eq("t4_ur_at_fe", 64'(lg_ur[fe]), 64'd1);
      cnt = 0;
      for (int i = st + 2; i < fe; i++) if (lg_c[i] == 4'h0) cnt++;
      check_eq("t4_data_words", 64'(cnt), 64'd5);
      cnt = 0;
      for (int i = fe + 1; i < lg_n; i++) if (lg_c[i] != 4'hF || lg_d[i] != 32'h07070707) cnt++;
      check_eq("t4_idle_after", 64'(cnt), 64'd0);
    end
    check_eq("t4_busy_end", {62'd0, tx_busy, s_ready}, 64'd0);

    // 5a: last keep 0011 -> FCS split 2/2, /T/ in lane 2
    for (int k = 0; k < 11; k++) fb[k] = 8'(8'hC0 + k * 3);
    fcs = fcs_of(10);
    log_start();
    send_frame(10, -1, -1);
    repeat (12) @(negedge clk);
    lg_en = 1'b0;
    check_frame("t5a", 0, 10, st, term, lane);
    check_eq("t5a_lane", 64'(lane), 64'd2);
    if (term > 0) begin
      check_eq("t5a_last", {lg_c[term-1], lg_d[term-1]},
               {4'h0, fcs[15:8], fcs[7:0], fb[9], fb[8]});
      check_eq("t5a_term", {lg_c[term], lg_d[term]},
               {4'b1100, 8'h07, 8'hFD, fcs[31:24], fcs[23:16]});
    end

    // 5b: last keep 0111 -> FCS split 1/3, /T/ in lane 3
    fcs = fcs_of(11);
    log_start();
    send_frame(11, -1, -1);
    repeat (12) @(negedge clk);
    lg_en = 1'b0;
    check_frame("t5b", 0, 11, st, term, lane);
    check_eq("t5b_lane", 64'(lane), 64'd3);
    if (term > 0) begin
      check_eq("t5b_last", {lg_c[term-1], lg_d[term-1]},
               {4'h0, fcs[7:0], fb[10], fb[9], fb[8]});
      check_eq("t5b_term", {lg_c[term], lg_d[term]},
               {4'b1000, 8'hFD, fcs[31:24], fcs[23:16], fcs[15:8]});
    end

    // 6: reset in the middle of ST_DATA, then a clean frame
    for (int k = 0; k < 40; k++) fb[k] = 8'(8'h11 * k);
    send_frame(40, -1, 3);
    @(negedge clk);
    check_eq("t6_rst_word", {txc, txd}, {4'hF, 32'h07070707});
    check_eq("t6_rst_ready", 64'(s_ready), 64'd0);
    check_eq("t6_rst_busy", 64'(tx_busy), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 14; k++) fb[k] = 8'(8'h9A - k);
    log_start();
    send_frame(14, -1, -1);
    repeat (12) @(negedge clk);
    lg_en = 1'b0;
    check_frame("t6", 0, 14, st, term, lane);
    check_eq("t6_lane", 64'(lane), 64'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
